instr_encoder: RTL and testbench

Packs structured RV32I instruction requests (format, opcode, register indices, funct fields, 32-bit immediate) into 32-bit instruction words and streams them into instruction memory at consecutive word addresses. It performs the inverse of instruction decode and serves as the program loader and self-test source in front of the instruction memory. Requests enter through a valid/ready handshake, are buffered in a small FIFO, and are drained under memory backpressure.

---
 rtl/instr_pkg.sv | 85 ++++++++
 rtl/instr_fifo.sv | 72 +++++++
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared RV32I encoding definitions: instruction formats, opcodes and the pure
// packing/legality function used by the encoder and by decode-side benches.
package instr_pkg;

   typedef enum logic [2:0] {
      FmtI       = 3'b000,
      FmtS       = 3'b001,
      FmtB       = 3'b010,
      FmtU       = 3'b011,
      FmtJ       = 3'b100,
      FmtIsh     = 3'b101,
      FmtR       = 3'b110,
      FmtIllegal = 3'b111
   } fmt_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      fmt_e        fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } instr_req_t;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } enc_result_t;

   // Immediates are byte offsets/values; range checks reject anything the field cannot hold.
   function automatic enc_result_t encode_instr(input instr_req_t r);
      enc_result_t res;
      logic        ok;
      res.word = '0;
      ok       = (r.opcode[1:0] == 2'b11);
      case (r.fmt)
         FmtR: begin
            res.word = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
         end
         FmtI: begin
            res.word = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            ok       = ok && (r.imm[31:11] == {21{r.imm[11]}});
         end
         FmtIsh: begin
            res.word = {r.funct7, r.imm[4:0], r.rs1, r.funct3, r.rd, r.opcode};
            ok       = ok && (r.imm[31:5] == '0);
         end
         FmtS: begin
            res.word = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            ok       = ok && (r.imm[31:11] == {21{r.imm[11]}});
         end
         FmtB: begin
            res.word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3, r.imm[4:1],
                        r.imm[11], r.opcode};
            ok       = ok && (r.imm[31:12] == {20{r.imm[12]}}) && !r.imm[0];
         end
         FmtU: begin
            res.word = {r.imm[31:12], r.rd, r.opcode};
            ok       = ok && (r.imm[11:0] == '0);
         end
         FmtJ: begin
            res.word = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.opcode};
            ok       = ok && (r.imm[31:20] == {12{r.imm[20]}}) && !r.imm[0];
         end
         default: begin
            ok = 1'b0;
         end
      endcase
      res.legal = ok;
      return res;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered full/empty flags; push is ignored when full and
// pop when empty.
module instr_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign do_push = push_i && !full_q;
   assign do_pop  = pop_i && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == FullCount);
      empty_d = (count_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: contents are only visible while not empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I instruction requests into words, buffers them and streams them into
// instruction memory at consecutive word addresses.
module instr_encoder #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [2:0]            fmt_i,
   input  logic [6:0]            opcode_i,
   input  logic [4:0]            rd_i,
   input  logic [4:0]            rs1_i,
   input  logic [4:0]            rs2_i,
   input  logic [2:0]            funct3_i,
   input  logic [6:0]            funct7_i,
   input  logic [31:0]           imm_i,
   input  logic                  start_i,
   output logic                  imem_wr_en_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [31:0]           imem_wdata_o,
   input  logic                  imem_ready_i,
   output logic                  illegal_o,
   output logic                  wrap_o
);

   import instr_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

   instr_req_t            req;
   enc_result_t           enc;
   logic                  accept, push, pop;
   logic                  fifo_full, fifo_empty;
   logic [31:0]           fifo_head;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  illegal_q, illegal_d;
   logic                  wrap_q, wrap_d;

   always_comb begin
      req.fmt    = fmt_e'(fmt_i);
      req.opcode = opcode_i;
      req.rd     = rd_i;
      req.rs1    = rs1_i;
      req.rs2    = rs2_i;
      req.funct3 = funct3_i;
      req.funct7 = funct7_i;
      req.imm    = imm_i;
      enc        = encode_instr(req);
   end

   // Illegal requests still handshake so the producer never stalls on them.
   assign accept = req_valid_i && req_ready_o;
   assign push   = accept && enc.legal;
   assign pop    = !fifo_empty && imem_ready_i;

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .wdata_i (enc.word),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // start_i wins over the increment; wrap goes to 0, never to BaseAddr.
   always_comb begin
      addr_d    = addr_q;
      wrap_d    = 1'b0;
      illegal_d = accept && !enc.legal;
      if (start_i) begin
         addr_d = BaseAddr;
      end else if (pop) begin
         addr_d = addr_q + ADDR_WIDTH'(1);
         wrap_d = &addr_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         addr_q    <= BaseAddr;
         illegal_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         addr_q    <= addr_d;
         illegal_q <= illegal_d;
         wrap_q    <= wrap_d;
      end
   end

   assign req_ready_o  = !fifo_full;
   assign imem_wr_en_o = !fifo_empty;
   assign imem_wdata_o = fifo_empty ? 32'h0 : fifo_head;
   assign imem_addr_o  = addr_q;
   assign illegal_o    = illegal_q;
   assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance plus a 2-bit-address instance
// with BASE_ADDR=1 for wrap-around and start_i behaviour.
module tb_instr_encoder;
   import instr_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  fmt, f3;
   logic [6:0]  opcode, f7;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm;

   logic        req_valid, imem_ready, start;
   logic        req_ready, wr_en, illegal, wrap;
   logic [9:0]  addr;
   logic [31:0] wdata;

   logic        w_req_valid, w_imem_ready, w_start;
   logic        w_req_ready, w_wr_en, w_illegal, w_wrap;
   logic [1:0]  w_addr;
   logic [31:0] w_wdata;

   int checks = 0;
   int errors = 0;
   int          log_addr[$];
   logic [31:0] log_data[$];
   int          w_log_addr[$];
   logic [31:0] w_log_data[$];

   // Expected addi x(i+1), x0, i+1 words, hand-packed.
   logic [31:0] addi_words [6];
   initial begin
      addi_words[0] = 32'h00100093; addi_words[1] = 32'h00200113;
      addi_words[2] = 32'h00300193; addi_words[3] = 32'h00400213;
      addi_words[4] = 32'h00500293; addi_words[5] = 32'h00600313;
   end

   instr_encoder #(.ADDR_WIDTH(10), .FIFO_DEPTH(4), .BASE_ADDR(0)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
      .funct3_i(f3), .funct7_i(f7), .imm_i(imm), .start_i(start),
      .imem_wr_en_o(wr_en), .imem_addr_o(addr), .imem_wdata_o(wdata),
      .imem_ready_i(imem_ready), .illegal_o(illegal), .wrap_o(wrap)
   );

   instr_encoder #(.ADDR_WIDTH(2), .FIFO_DEPTH(4), .BASE_ADDR(1)) dut_w (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(w_req_valid), .req_ready_o(w_req_ready),
      .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
      .funct3_i(f3), .funct7_i(f7), .imm_i(imm), .start_i(w_start),
      .imem_wr_en_o(w_wr_en), .imem_addr_o(w_addr), .imem_wdata_o(w_wdata),
      .imem_ready_i(w_imem_ready), .illegal_o(w_illegal), .wrap_o(w_wrap)
   );

   // Record each completing write (sampled mid-cycle, completes at next rising edge).
   always @(negedge clk) begin
      if (wr_en && imem_ready) begin
         log_addr.push_back(int'(addr));
         log_data.push_back(wdata);
      end
      if (w_wr_en && w_imem_ready) begin
         w_log_addr.push_back(int'(w_addr));
         w_log_data.push_back(w_wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2,
                             input logic [2:0] fn3, input logic [6:0] fn7,
                             input logic [31:0] im);
      fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
   endtask

   task automatic send(input bit to_w, input logic [2:0] f, input logic [6:0] op,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [2:0] fn3, input logic [6:0] fn7, input logic [31:0] im);
      set_fields(f, op, d, s1, s2, fn3, fn7, im);
      if (to_w) w_req_valid = 1'b1; else req_valid = 1'b1;
      tick();
      w_req_valid = 1'b0;
      req_valid   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 0; imem_ready = 0; start = 0;
      w_req_valid = 0; w_imem_ready = 0; w_start = 0;
      set_fields(3'b000, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      #12;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      checks++; if (addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
      checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
      checks++; if (illegal !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL reset_pulses: illegal=%b wrap=%b want 0 0", illegal, wrap); end
      checks++; if (w_addr !== 2'd1) begin errors++; $display("FAIL reset_w_addr: got %0d want 1", w_addr); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_addi();
      imem_ready = 1'b0;
      send(0, FmtI, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      checks++; if (wr_en !== 1'b1 || addr !== 10'd0 || wdata !== 32'h00500093) begin
         errors++; $display("FAIL addi_latency: wr_en=%b addr=%0d wdata=%h want 1 0 00500093", wr_en, addr, wdata); end
      tick();
      checks++; if (wr_en !== 1'b1 || addr !== 10'd0 || wdata !== 32'h00500093) begin
         errors++; $display("FAIL addi_stall_stable: wr_en=%b addr=%0d wdata=%h want 1 0 00500093", wr_en, addr, wdata); end
      imem_ready = 1'b1;
      tick();
      checks++; if (wr_en !== 1'b0 || addr !== 10'd1 || log_addr.size() != 1) begin
         errors++; $display("FAIL addi_complete: wr_en=%b addr=%0d writes=%0d want 0 1 1", wr_en, addr, log_addr.size()); end
   endtask

   task automatic test_beq_lui();
      imem_ready = 1'b1;
      send(0, FmtB, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFF8);
      checks++; if (wdata !== 32'hFE208CE3 || addr !== 10'd1) begin
         errors++; $display("FAIL beq_word: wdata=%h addr=%0d want FE208CE3 1", wdata, addr); end
      send(0, FmtU, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      checks++; if (wdata !== 32'h123452B7 || addr !== 10'd2) begin
         errors++; $display("FAIL lui_word: wdata=%h addr=%0d want 123452B7 2", wdata, addr); end
      tick();
      checks++; if (wr_en !== 1'b0 || addr !== 10'd3) begin
         errors++; $display("FAIL beq_lui_drain: wr_en=%b addr=%0d want 0 3", wr_en, addr); end
   endtask

   task automatic test_illegal();
      logic [2:0]  fl [8];
      logic [6:0]  ol [8];
      logic [31:0] il [8];
      int n0;
      fl[0] = FmtJ;   ol[0] = OP_JAL;     il[0] = 32'd3;
      fl[1] = 3'b111; ol[1] = OP_IMM;     il[1] = 32'd0;
      fl[2] = FmtR;   ol[2] = 7'b0110000; il[2] = 32'd0;
      fl[3] = FmtU;   ol[3] = OP_LUI;     il[3] = 32'h12345001;
      fl[4] = FmtIsh; ol[4] = OP_IMM;     il[4] = 32'h20;
      fl[5] = FmtI;   ol[5] = OP_IMM;     il[5] = 32'h800;
      fl[6] = FmtB;   ol[6] = OP_BRANCH;  il[6] = 32'h1000;
      fl[7] = FmtS;   ol[7] = OP_STORE;   il[7] = 32'hFFFFF7FF;
      imem_ready = 1'b1;
      n0 = log_addr.size();
      for (int i = 0; i < 8; i++) begin
         send(0, fl[i], ol[i], 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, il[i]);
         checks++; if (illegal !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL illegal_case%0d: illegal=%b wr_en=%b want 1 0", i, illegal, wr_en); end
      end
      tick();
      checks++; if (illegal !== 1'b0 || addr !== 10'd3 || log_addr.size() != n0) begin
         errors++; $display("FAIL illegal_after: illegal=%b addr=%0d writes=%0d want 0 3 %0d", illegal, addr, log_addr.size(), n0); end
   endtask

   task automatic test_formats();
      logic [2:0]  fl [6];
      logic [6:0]  ol [6];
      logic [4:0]  dl [6];
      logic [2:0]  f3l [6];
      logic [6:0]  f7l [6];
      logic [31:0] il [6];
      logic [31:0] exp_w [6];
      fl[0] = FmtS;   ol[0] = OP_STORE;  dl[0] = 5'd0; f3l[0] = 3'b010; f7l[0] = 7'd0;         il[0] = 32'hFFFFFFFC; exp_w[0] = 32'hFE20AE23;
      fl[1] = FmtJ;   ol[1] = OP_JAL;    dl[1] = 5'd1; f3l[1] = 3'b000; f7l[1] = 7'd0;         il[1] = 32'h800;      exp_w[1] = 32'h001000EF;
      fl[2] = FmtR;   ol[2] = OP_REG;    dl[2] = 5'd3; f3l[2] = 3'b000; f7l[2] = 7'b0100000;   il[2] = 32'd0;        exp_w[2] = 32'h402081B3;
      fl[3] = FmtIsh; ol[3] = OP_IMM;    dl[3] = 5'd1; f3l[3] = 3'b001; f7l[3] = 7'd0;         il[3] = 32'd31;       exp_w[3] = 32'h01F09093;
      fl[4] = FmtI;   ol[4] = OP_IMM;    dl[4] = 5'd0; f3l[4] = 3'b000; f7l[4] = 7'd0;         il[4] = 32'hFFFFF800; exp_w[4] = 32'h80000013;
      fl[5] = FmtB;   ol[5] = OP_BRANCH; dl[5] = 5'd0; f3l[5] = 3'b000; f7l[5] = 7'd0;         il[5] = 32'hFFE;      exp_w[5] = 32'h7E000FE3;
      imem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         // rs1/rs2 only meaningful for some formats; sw/sub use rs1=1 rs2=2, beq uses x0,x0.
         send(0, fl[i], ol[i], dl[i], (i == 5) ? 5'd0 : ((i == 4) ? 5'd0 : 5'd1),
              (i == 5) ? 5'd0 : 5'd2, f3l[i], f7l[i], il[i]);
         checks++; if (wr_en !== 1'b1 || wdata !== exp_w[i]) begin
            errors++; $display("FAIL format_case%0d: wr_en=%b wdata=%h want 1 %h", i, wr_en, wdata, exp_w[i]); end
      end
      tick();
   endtask

   task automatic test_backpressure();
      bit acc;
      rst_n = 1'b0; #2; rst_n = 1'b1;
      tick();
      log_addr.delete(); log_data.delete();
      imem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_fields(FmtI, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
         req_valid = 1'b1;
         @(negedge clk);
         checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b want 1", i, req_ready); end
         tick();
      end
      set_fields(FmtI, OP_IMM, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      imem_ready = 1'b1;
      @(negedge clk);
      // Full FIFO: the pop in this cycle only frees a slot from the next cycle on.
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", req_ready); end
      tick();
      for (int i = 4; i < 6; i++) begin
         set_fields(FmtI, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
         req_valid = 1'b1;
         acc = 1'b0;
         for (int c = 0; c < 16 && !acc; c++) begin
            @(negedge clk);
            acc = req_ready;
            tick();
         end
         checks++; if (!acc) begin errors++; $display("FAIL bp_accept_%0d: not accepted within 16 cycles", i); end
      end
      req_valid = 1'b0;
      repeat (8) tick();
      checks++; if (log_addr.size() != 6) begin errors++; $display("FAIL bp_count: got %0d writes want 6", log_addr.size()); end
      for (int k = 0; k < log_addr.size() && k < 6; k++) begin
         checks++; if (log_addr[k] != k || log_data[k] !== addi_words[k]) begin
            errors++; $display("FAIL bp_write_%0d: addr=%0d data=%h want %0d %h", k, log_addr[k], log_data[k], k, addi_words[k]); end
      end
   endtask

   task automatic test_wrap_start();
      logic [1:0] exp_a [5];
      logic       exp_wr [5];
      int         exp_la [5];
      exp_a[0] = 2'd1; exp_a[1] = 2'd2; exp_a[2] = 2'd3; exp_a[3] = 2'd0; exp_a[4] = 2'd1;
      exp_wr[0] = 0; exp_wr[1] = 0; exp_wr[2] = 0; exp_wr[3] = 1; exp_wr[4] = 0;
      exp_la[0] = 1; exp_la[1] = 2; exp_la[2] = 3; exp_la[3] = 0; exp_la[4] = 1;
      w_log_addr.delete(); w_log_data.delete();
      w_imem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         set_fields(FmtI, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
         w_req_valid = 1'b1;
         tick();
         checks++; if (w_addr !== exp_a[i] || w_wrap !== exp_wr[i] || w_illegal !== 1'b0) begin
            errors++; $display("FAIL wrap_step%0d: addr=%0d wrap=%b illegal=%b want %0d %b 0", i, w_addr, w_wrap, w_illegal, exp_a[i], exp_wr[i]); end
      end
      w_req_valid = 1'b0;
      tick();
      checks++; if (w_addr !== 2'd2 || w_wrap !== 1'b0 || w_wr_en !== 1'b0) begin
         errors++; $display("FAIL wrap_drain: addr=%0d wrap=%b wr_en=%b want 2 0 0", w_addr, w_wrap, w_wr_en); end
      for (int k = 0; k < 5 && k < w_log_addr.size(); k++) begin
         checks++; if (w_log_addr[k] != exp_la[k] || w_log_data[k] !== addi_words[k]) begin
            errors++; $display("FAIL wrap_write_%0d: addr=%0d data=%h want %0d %h", k, w_log_addr[k], w_log_data[k], exp_la[k], addi_words[k]); end
      end
      w_imem_ready = 1'b0;
      send(1, FmtI, OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
      set_fields(FmtI, OP_IMM, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
      w_req_valid = 1'b1; w_start = 1'b1; w_imem_ready = 1'b1;
      tick();
      w_req_valid = 1'b0; w_start = 1'b0;
      checks++; if (w_addr !== 2'd1 || w_wdata !== 32'h00800413 || w_wrap !== 1'b0) begin
         errors++; $display("FAIL start_load: addr=%0d wdata=%h wrap=%b want 1 00800413 0", w_addr, w_wdata, w_wrap); end
      tick();
      checks++; if (w_log_addr.size() != 7) begin
         errors++; $display("FAIL start_count: got %0d writes want 7", w_log_addr.size()); end
      else begin
         checks++; if (w_log_addr[5] != 2 || w_log_data[5] !== 32'h00700393 ||
                       w_log_addr[6] != 1 || w_log_data[6] !== 32'h00800413) begin
            errors++; $display("FAIL start_writes: (%0d,%h) (%0d,%h) want (2,00700393) (1,00800413)",
                               w_log_addr[5], w_log_data[5], w_log_addr[6], w_log_data[6]); end
      end
   endtask

   task automatic test_reset_mid();
      int n0;
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(0, FmtI, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1));
      checks++; if (wr_en !== 1'b1 || req_ready !== 1'b1) begin
         errors++; $display("FAIL mid_buffered: wr_en=%b ready=%b want 1 1", wr_en, req_ready); end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (wr_en !== 1'b0 || req_ready !== 1'b1 || addr !== 10'd0 || wdata !== 32'h0) begin
         errors++; $display("FAIL mid_async_reset: wr_en=%b ready=%b addr=%0d wdata=%h want 0 1 0 0", wr_en, req_ready, addr, wdata); end
      #1; rst_n = 1'b1;
      n0 = log_addr.size();
      imem_ready = 1'b1;
      tick();
      send(0, FmtI, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      checks++; if (addr !== 10'd0 || wdata !== 32'h00500093) begin
         errors++; $display("FAIL mid_first_new: addr=%0d wdata=%h want 0 00500093", addr, wdata); end
      tick();
      checks++; if (log_addr.size() != n0 + 1 || addr !== 10'd1) begin
         errors++; $display("FAIL mid_no_stale: writes=%0d addr=%0d want %0d 1", log_addr.size(), addr, n0 + 1); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_beq_lui();
      test_illegal();
      test_formats();
      test_backpressure();
      test_wrap_start();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
